roberto_tx_serial: RTL and testbench
====================================

Name: roberto_tx_serial

Overview:
- Asynchronous serial transmitter, directly downstream of the Spilling measurement control unit.
- On a level `partida` request from the UC (its `partida_tx` output), serialises one byte in 8N1 format (LSB first) on `saida_serial`.
- Returns a one-cycle `pronto` pulse, which the UC consumes as `pronto_serial`.
- Synchronous `zera` (driven by UC `zera_serial`) aborts and returns to idle.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200 baud); legal range 2..65535.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- zera  input  1  synchronous clear, active-high; same effect as reset but sampled on the clock.
- partida  input  1  transmit request, level-sensitive, sampled only in idle.
- dados  input  8  byte to send; captured on the cycle partida is accepted.
- saida_serial  output  1  serial line; idle level is 1.
- ocupado  output  1  high from acceptance until the final state ends.
- pronto  output  1  one-cycle pulse after the last stop bit completes.
- db_estado  output  3  debug encoding of the current state.

Behaviour:
- Reset/zera values:
  - state = inicial; saida_serial = 1; ocupado = 0; pronto = 0.
  - Tick counter = 0, bit counter = 0, shift register = 0.
- States and db_estado encoding:
  - inicial 000, inicio 001, dado 010, paridade 011, parada 100, final 101; any other encoding gives 111.
- inicial:
  - saida_serial = 1.
  - If partida = 1: latch dados into the shift register, clear counters, go to inicio on the next edge.
  - Otherwise stay in inicial.
- inicio:
  - saida_serial = 0 for CLKS_PER_BIT cycles, then go to dado.
- dado:
  - saida_serial = shift[0].
  - At the end of each bit period, shift right and increment the bit counter.
  - After bit 7 completes, go to paridade if the feature is compiled in, else to parada.
- parada:
  - saida_serial = 1 for STOP_BITS × CLKS_PER_BIT cycles, then go to final.
- final:
  - pronto = 1 for exactly one cycle; saida_serial = 1; return to inicial.
- Bit period: the tick counter counts 0..CLKS_PER_BIT-1. The end-of-bit strobe fires when count = CLKS_PER_BIT-1, and the counter wraps to 0.
- Timing:
  - The first start-bit cycle is the cycle after partida is sampled.
  - Frame length = (10 + STOP_BITS - 1) × CLKS_PER_BIT cycles, plus 1 cycle for the final state.
- ocupado = 1 in every state except inicial.
- partida is ignored outside inicial. The UC holds partida high through the pronto cycle; because final always returns to inicial, a held partida starts a new frame only after one idle cycle.
- dados changes after acceptance have no effect on the frame in progress.
- zera or reset mid-frame:
  - Line returns to 1 immediately (next edge for zera, asynchronous for reset).
  - pronto is not issued.
- Reset and zera both asserted: reset dominates.
- All outputs are registered or decoded from the state register only (Moore); no combinational path from partida to saida_serial.

Optional Feature:
- Macro: SERIAL_PARITY_EN.
- Defined:
  - Frame is 8E1.
  - The paridade state drives the XOR of the 8 latched data bits (even parity) for one bit period, then goes to parada.
  - Frame length increases by one bit period.
- Undefined:
  - paridade state logic is not compiled.
  - dado goes directly to parada.
  - Encoding 011 is unused and maps to db_estado 111 if ever reached.

Decomposition:
- Package roberto_serial_pkg:
  - State encoding localparams (TX_INICIAL..TX_FINAL).
  - TX_DB_ERRO = 3'b111.
  - TX_LINHA_IDLE = 1'b1.
  - Default CLKS_PER_BIT constant.
- Sub-module roberto_tick_baud:
  - Parameterised modulo-CLKS_PER_BIT counter with enable and synchronous clear.
  - Outputs a one-cycle end-of-bit strobe.
  - Instantiated once; cleared on every state entry.

Test Plan:
- CLKS_PER_BIT = 4, STOP_BITS = 1, dados = 8'h55, one-cycle partida → line sequence 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles; pronto high exactly 1 cycle, 40 cycles after the first start-bit cycle; ocupado low afterward.
- partida held high continuously with dados = 8'hA3 → two back-to-back frames separated by exactly one idle cycle (line = 1); pronto pulses twice.
- zera asserted at cycle 15 of an 8'hFF frame → saida_serial = 1 and state inicial on the next edge; no pronto; a following request with 8'h0F transmits correctly.
- reset asserted asynchronously mid-dado (between clock edges) → saida_serial = 1 and db_estado = 000 immediately, without waiting for an edge.
- STOP_BITS = 2, dados = 8'h00 → stop interval of 8 cycles at line 1 before pronto.
- SERIAL_PARITY_EN defined, dados = 8'h07 → parity bit = 1, frame of 11 bits; dados = 8'h03 → parity bit = 0.

Source files
------------

// File: rtl/roberto_serial_pkg.sv
// rtl/roberto_serial_pkg.sv - shared constants for the roberto serial transmitter
//
// Purpose: state encodings, debug error code, idle line level and default
//          bit period shared by roberto_tx_serial and roberto_tick_baud.
// Ports:   none (package).
// Macro:   SERIAL_PARITY_EN (consumed by roberto_tx_serial; TX_PARIDADE is
//          only reachable when it is defined).

package roberto_serial_pkg;

  localparam logic [2:0] TX_INICIAL  = 3'b000;
  localparam logic [2:0] TX_INICIO   = 3'b001;
  localparam logic [2:0] TX_DADO     = 3'b010;
  localparam logic [2:0] TX_PARIDADE = 3'b011;
  localparam logic [2:0] TX_PARADA   = 3'b100;
  localparam logic [2:0] TX_FINAL    = 3'b101;

  localparam logic [2:0] TX_DB_ERRO    = 3'b111;
  localparam logic       TX_LINHA_IDLE = 1'b1;

  // 50 MHz clock / 115200 baud
  localparam int TX_CLKS_PER_BIT_DEFAULT = 434;

  typedef enum logic [2:0] {
    ST_INICIAL  = TX_INICIAL,
    ST_INICIO   = TX_INICIO,
    ST_DADO     = TX_DADO,
    ST_PARIDADE = TX_PARIDADE,
    ST_PARADA   = TX_PARADA,
    ST_FINAL    = TX_FINAL
  } tx_estado_t;

endpackage

// File: rtl/roberto_tick_baud.sv
// rtl/roberto_tick_baud.sv - modulo-CLKS_PER_BIT bit-period counter
//
// Purpose: counts 0..CLKS_PER_BIT-1 while enabled and raises a one-cycle
//          end-of-bit strobe on the last count, wrapping to 0.
// Ports:
//   clock  in   system clock, rising edge
//   reset  in   asynchronous active-high reset
//   enable in   count enable
//   clear  in   synchronous clear (takes priority over enable)
//   tick   out  end-of-bit strobe, high while count == CLKS_PER_BIT-1 and enabled

module roberto_tick_baud
  import roberto_serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = TX_CLKS_PER_BIT_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] ULTIMO = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] contagem;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      contagem <= '0;
    end else if (clear) begin
      contagem <= '0;
    end else if (enable) begin
      contagem <= (contagem == ULTIMO) ? '0 : contagem + 1'b1;
    end
  end

  assign tick = enable && (contagem == ULTIMO);

endmodule

// File: rtl/roberto_tx_serial.sv
// rtl/roberto_tx_serial.sv - 8N1 (or 8E1) asynchronous serial transmitter
//
// Purpose: on a level partida request in idle, latches dados and sends it
//          LSB first with one start bit and STOP_BITS stop bits, then pulses
//          pronto for one cycle. zera is a synchronous abort to idle.
// Macro:   SERIAL_PARITY_EN - when defined, an even parity bit is sent
//          between the data and stop bits (8E1).
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   asynchronous active-high reset
//   zera         in   synchronous clear, active-high
//   partida      in   transmit request, sampled only in idle
//   dados[7:0]   in   byte to send, captured on acceptance
//   saida_serial out  serial line, idle high
//   ocupado      out  high in every state except idle
//   pronto       out  one-cycle pulse after the last stop bit
//   db_estado    out  debug state encoding (111 for unknown encodings)

module roberto_tx_serial
  import roberto_serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = TX_CLKS_PER_BIT_DEFAULT,
  parameter int STOP_BITS    = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       zera,
  input  logic       partida,
  input  logic [7:0] dados,
  output logic       saida_serial,
  output logic       ocupado,
  output logic       pronto,
  output logic [2:0] db_estado
);

  localparam logic [2:0] ULTIMA_PARADA = 3'(STOP_BITS - 1);

  tx_estado_t estado;
  tx_estado_t prox;
  logic [7:0] shift;
  logic [2:0] bit_cnt;
  logic       tick;
  logic       entrada;

  // Any state change restarts both the bit period and the bit counter, so
  // every state begins with a full bit period.
  assign entrada = (prox != estado);

  roberto_tick_baud #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tick (
    .clock (clock),
    .reset (reset),
    .enable(ocupado),
    .clear (entrada || zera),
    .tick  (tick)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado  <= ST_INICIAL;
      shift   <= '0;
      bit_cnt <= '0;
    end else if (zera) begin
      estado  <= ST_INICIAL;
      shift   <= '0;
      bit_cnt <= '0;
    end else begin
      estado <= prox;
      if (estado == ST_INICIAL) begin
        if (partida) begin
          shift   <= dados;
          bit_cnt <= '0;
        end
      end else if (entrada) begin
        bit_cnt <= '0;
      end else if (tick) begin
        // In dado bit_cnt counts data bits; in parada it counts stop bits.
        bit_cnt <= bit_cnt + 3'd1;
        if (estado == ST_DADO) begin
          shift <= {1'b0, shift[7:1]};
        end
      end
    end
  end

`ifdef SERIAL_PARITY_EN
  logic paridade_bit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      paridade_bit <= 1'b0;
    end else if (zera) begin
      paridade_bit <= 1'b0;
    end else if (estado == ST_INICIAL && partida) begin
      paridade_bit <= ^dados;
    end
  end
`endif

  always_comb begin
    prox = estado;
    case (estado)
      ST_INICIAL: begin
        if (partida) prox = ST_INICIO;
      end
      ST_INICIO: begin
        if (tick) prox = ST_DADO;
      end
      ST_DADO: begin
        if (tick && bit_cnt == 3'd7) begin
`ifdef SERIAL_PARITY_EN
          prox = ST_PARIDADE;
`else
          prox = ST_PARADA;
`endif
        end
      end
`ifdef SERIAL_PARITY_EN
      ST_PARIDADE: begin
        if (tick) prox = ST_PARADA;
      end
`endif
      ST_PARADA: begin
        if (tick && bit_cnt == ULTIMA_PARADA) prox = ST_FINAL;
      end
      ST_FINAL: begin
        prox = ST_INICIAL;
      end
      default: begin
        prox = ST_INICIAL;
      end
    endcase
  end

  // Outputs depend only on registers, so reset forces the idle line level
  // immediately and partida never reaches saida_serial combinationally.
  always_comb begin
    saida_serial = TX_LINHA_IDLE;
    ocupado      = 1'b1;
    pronto       = 1'b0;
    db_estado    = TX_DB_ERRO;
    case (estado)
      ST_INICIAL: begin
        ocupado   = 1'b0;
        db_estado = TX_INICIAL;
      end
      ST_INICIO: begin
        saida_serial = 1'b0;
        db_estado    = TX_INICIO;
      end
      ST_DADO: begin
        saida_serial = shift[0];
        db_estado    = TX_DADO;
      end
`ifdef SERIAL_PARITY_EN
      ST_PARIDADE: begin
        saida_serial = paridade_bit;
        db_estado    = TX_PARIDADE;
      end
`endif
      ST_PARADA: begin
        db_estado = TX_PARADA;
      end
      ST_FINAL: begin
        pronto    = 1'b1;
        db_estado = TX_FINAL;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_roberto_tx_serial.sv
// tb/tb_roberto_tx_serial.sv - scoreboard bench for roberto_tx_serial
//
// Unit 0: CLKS_PER_BIT=4, STOP_BITS=1. Unit 1: CLKS_PER_BIT=4, STOP_BITS=2.
// Macro SERIAL_PARITY_EN adds the expected parity bit to every frame.

module tb_roberto_tx_serial;

  localparam int C = 4;
`ifdef SERIAL_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  typedef struct {
    logic [7:0] data;
    int         cut;
    bit         b2b;
  } frame_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0 = 1'b1, rst1 = 1'b1;
  logic       zera0 = 1'b0, zera1 = 1'b0;
  logic       partida0 = 1'b0, partida1 = 1'b0;
  logic [7:0] dados0 = 8'h00, dados1 = 8'h00;
  logic       line0, line1, ocup0, ocup1, pronto0, pronto1;
  logic [2:0] db0, db1;

  int total  = 0;
  int passed = 0;
  frame_t q0[$];
  frame_t q1[$];

  roberto_tx_serial #(.CLKS_PER_BIT(C), .STOP_BITS(1)) dut0 (
    .clock(clk), .reset(rst0), .zera(zera0), .partida(partida0), .dados(dados0),
    .saida_serial(line0), .ocupado(ocup0), .pronto(pronto0), .db_estado(db0)
  );

  roberto_tx_serial #(.CLKS_PER_BIT(C), .STOP_BITS(2)) dut1 (
    .clock(clk), .reset(rst1), .zera(zera1), .partida(partida1), .dados(dados1),
    .saida_serial(line1), .ocupado(ocup1), .pronto(pronto1), .db_estado(db1)
  );

  task automatic chk(string name, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  function automatic int g_line(int u);   return (u == 0) ? int'(line0)   : int'(line1);   endfunction
  function automatic int g_ocup(int u);   return (u == 0) ? int'(ocup0)   : int'(ocup1);   endfunction
  function automatic int g_pronto(int u); return (u == 0) ? int'(pronto0) : int'(pronto1); endfunction
  function automatic int g_db(int u);     return (u == 0) ? int'(db0)     : int'(db1);     endfunction
  function automatic int qsize(int u);    return (u == 0) ? q0.size()     : q1.size();     endfunction

  // Unit u has u+1 stop bits.
  function automatic int nbits(int u);
    return 10 + u + PAR;
  endfunction

  // Expected line level and debug state in frame cycle k (0 = first start-bit cycle).
  function automatic void exp_at(logic [7:0] d, int k, output int ln, output int st);
    int b;
    b = k / C;
    if (b == 0) begin
      ln = 0; st = 1;
    end else if (b <= 8) begin
      ln = int'(d[b-1]); st = 2;
    end else if (PAR == 1 && b == 9) begin
      ln = int'(^d); st = 3;
    end else begin
      ln = 1; st = 4;
    end
  endfunction

  task automatic chk_idle(int u, string tag);
    chk($sformatf("u%0d %s ocupado", u, tag), g_ocup(u), 0);
    chk($sformatf("u%0d %s line", u, tag), g_line(u), 1);
    chk($sformatf("u%0d %s pronto", u, tag), g_pronto(u), 0);
    chk($sformatf("u%0d %s db_estado", u, tag), g_db(u), 0);
  endtask

  task automatic mon(int u);
    frame_t f;
    bit pend;
    int n, ln, st;
    pend = 0;
    forever begin
      @(negedge clk);
      if (g_ocup(u) == 0) begin
        if (pend) chk($sformatf("u%0d back-to-back restart ocupado", u), 0, 1);
        pend = 0;
        chk($sformatf("u%0d idle line", u), g_line(u), 1);
        chk($sformatf("u%0d idle pronto", u), g_pronto(u), 0);
        continue;
      end
      pend = 0;
      if (qsize(u) == 0) begin
        chk($sformatf("u%0d unexpected frame", u), 1, 0);
        do @(negedge clk); while (g_ocup(u) != 0);
        continue;
      end
      if (u == 0) f = q0.pop_front();
      else        f = q1.pop_front();
      n = nbits(u) * C;
      for (int k = 0; k <= n + 1; k++) begin
        if (k > 0) @(negedge clk);
        if (k == f.cut || k == n + 1) begin
          chk_idle(u, $sformatf("after frame %02h k=%0d", f.data, k));
          break;
        end
        if (k == n) begin
          chk($sformatf("u%0d final pronto %02h", u, f.data), g_pronto(u), 1);
          chk($sformatf("u%0d final line %02h", u, f.data), g_line(u), 1);
          chk($sformatf("u%0d final ocupado %02h", u, f.data), g_ocup(u), 1);
          chk($sformatf("u%0d final db_estado %02h", u, f.data), g_db(u), 5);
        end else begin
          exp_at(f.data, k, ln, st);
          chk($sformatf("u%0d line %02h k=%0d", u, f.data, k), g_line(u), ln);
          chk($sformatf("u%0d db_estado %02h k=%0d", u, f.data, k), g_db(u), st);
          chk($sformatf("u%0d pronto %02h k=%0d", u, f.data, k), g_pronto(u), 0);
          chk($sformatf("u%0d ocupado %02h k=%0d", u, f.data, k), g_ocup(u), 1);
        end
      end
      pend = f.b2b;
    end
  endtask

  task automatic drive(int u, logic p, logic [7:0] d);
    if (u == 0) begin partida0 = p; dados0 = d; end
    else        begin partida1 = p; dados1 = d; end
  endtask

  task automatic push(int u, logic [7:0] d, int cut, bit b2b);
    frame_t f;
    f.data = d; f.cut = cut; f.b2b = b2b;
    if (u == 0) q0.push_back(f);
    else        q1.push_back(f);
  endtask

  // One-cycle partida; returns at the negedge of frame cycle 0 with dados scrambled.
  task automatic send(int u, logic [7:0] d);
    @(negedge clk);
    drive(u, 1'b1, d);
    @(negedge clk);
    drive(u, 1'b0, ~d);
  endtask

  task automatic wait_idle(int u);
    int i;
    for (i = 0; i < 400; i++) begin
      @(negedge clk);
      if (qsize(u) == 0 && g_ocup(u) == 0) break;
    end
    chk($sformatf("u%0d idle within bound", u), int'(i < 400), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    fork
      mon(0);
      mon(1);
    join_none
  end

  initial begin
    int cnt;
    repeat (2) @(negedge clk);
    for (int u = 0; u < 2; u++) chk_idle(u, "reset");
    rst0 = 1'b0;
    rst1 = 1'b0;
    repeat (2) @(negedge clk);

    // 0x55, 8N1 (or 8E1), one-cycle request
    push(0, 8'h55, -1, 0);
    send(0, 8'h55);
    wait_idle(0);

    // held partida: two A3 frames with exactly one idle cycle between them
    push(0, 8'hA3, -1, 1);
    push(0, 8'hA3, -1, 0);
    @(negedge clk);
    drive(0, 1'b1, 8'hA3);
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (pronto0) begin
        cnt++;
        if (cnt == 2) break;
      end
    end
    drive(0, 1'b0, 8'h00);
    chk("held partida pronto count", cnt, 2);
    wait_idle(0);

    // zera during an FF frame, then a clean 0F frame
    push(0, 8'hFF, 15, 0);
    send(0, 8'hFF);
    repeat (14) @(negedge clk);
    zera0 = 1'b1;
    @(negedge clk);
    zera0 = 1'b0;
    push(0, 8'h0F, -1, 0);
    send(0, 8'h0F);
    wait_idle(0);

    // asynchronous reset while a 0 data bit is on the line
    push(0, 8'hE7, 20, 0);
    send(0, 8'hE7);
    repeat (19) @(negedge clk);
    #2;
    chk("pre-reset line", int'(line0), 0);
    rst0 = 1'b1;
    #1;
    chk("async reset line", int'(line0), 1);
    chk("async reset db_estado", int'(db0), 0);
    chk("async reset ocupado", int'(ocup0), 0);
    @(negedge clk);
    #2 rst0 = 1'b0;
    wait_idle(0);

    // two stop bits
    push(1, 8'h00, -1, 0);
    send(1, 8'h00);
    wait_idle(1);
    push(1, 8'hC5, -1, 0);
    send(1, 8'hC5);
    wait_idle(1);

    // parity-sensitive bytes (odd and even popcount)
    push(0, 8'h07, -1, 0);
    send(0, 8'h07);
    wait_idle(0);
    push(0, 8'h03, -1, 0);
    send(0, 8'h03);
    wait_idle(0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
